// File: rtl/guess_arbiter.sv
// Round sequencer for the hangman datapath: round-robin keypad arbitration, letter
// normalisation, repeat filtering and guess issue/ack handshake.
// state | meaning: IDLE no round | START start pulse | WAIT_RDY datapath ready | ARB pick player
//   CHECK validate letter | ISSUE wait red_busy | EVAL wait result | DONE game over, wait word drop
module guess_arbiter #(
  parameter int NUM_PLAYERS = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     word_valid,
  input  logic [NUM_PLAYERS-1:0]   req,
  input  logic [8*NUM_PLAYERS-1:0] req_letter,
  input  logic                     game_rdy,
  input  logic                     red_busy,
  input  logic                     game_over,
  output logic                     toggle_state,
  output logic [7:0]               guess,
  output logic [NUM_PLAYERS-1:0]   grant,
  output logic                     reject,
  output logic                     timeout_err,
  output logic [2:0]               turn,
  output logic [25:0]              guessed_mask,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_RDY, ARB, CHECK, ISSUE, EVAL, DONE
  } state_t;

  state_t state, state_next;

  logic [2:0]  ptr;
  logic [7:0]  letter;
  logic [7:0]  cnt;

  logic                   hi_found, lo_found, pick_found;
  logic [2:0]             hi_idx, lo_idx, pick_idx, ptr_next;
  logic [7:0]             hi_letter, lo_letter, pick_letter;
  logic [NUM_PLAYERS-1:0] pick_onehot;

  logic [7:0]  norm;
  logic [4:0]  letter_idx;
  logic [25:0] letter_onehot;
  logic        letter_ok, accept;

  logic do_start, do_grant, do_reject, do_accept, do_timeout;

  // Descending scan leaves the lowest matching index; "hi" only considers players at or after ptr.
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    hi_letter = '0;
    lo_letter = '0;
    for (int j = NUM_PLAYERS - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_found  = 1'b1;
        lo_idx    = 3'(j);
        lo_letter = req_letter[8*j +: 8];
        if (j >= int'(ptr)) begin
          hi_found  = 1'b1;
          hi_idx    = 3'(j);
          hi_letter = req_letter[8*j +: 8];
        end
      end
    end
    pick_found  = lo_found;
    pick_idx    = hi_found ? hi_idx : lo_idx;
    pick_letter = hi_found ? hi_letter : lo_letter;
    pick_onehot = NUM_PLAYERS'(1) << pick_idx;
    ptr_next    = (pick_idx == 3'(NUM_PLAYERS - 1)) ? 3'd0 : pick_idx + 3'd1;
  end

  always_comb begin
    norm          = (letter >= 8'h61 && letter <= 8'h7A) ? letter - 8'h20 : letter;
    letter_ok     = (norm >= 8'h41) && (norm <= 8'h5A);
    letter_idx    = 5'(norm - 8'h41);
    letter_onehot = 26'd1 << letter_idx;
    accept        = letter_ok && ((guessed_mask & letter_onehot) == 26'd0);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_grant   = 1'b0;
    do_reject  = 1'b0;
    do_accept  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE:     if (word_valid) begin
                  state_next = START;
                  do_start   = 1'b1;
                end
      START:    state_next = WAIT_RDY;
      WAIT_RDY: if (game_rdy) state_next = ARB;
      ARB:      if (game_over) state_next = DONE;
                else if (pick_found) begin
                  state_next = CHECK;
                  do_grant   = 1'b1;
                end
      CHECK:    if (accept) begin
                  state_next = ISSUE;
                  do_accept  = 1'b1;
                end else begin
                  state_next = ARB;
                  do_reject  = 1'b1;
                end
      ISSUE:    if (red_busy) state_next = EVAL;
                else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
                  state_next = ARB;
                  do_timeout = 1'b1;
                end
      EVAL:     if (game_rdy && !red_busy) state_next = ARB;
      DONE:     if (!word_valid) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      toggle_state <= 1'b0;
      guess        <= '0;
      grant        <= '0;
      reject       <= 1'b0;
      timeout_err  <= 1'b0;
      turn         <= '0;
      guessed_mask <= '0;
      ptr          <= '0;
      letter       <= '0;
      cnt          <= '0;
    end else begin
      toggle_state <= do_start;
      grant        <= do_grant ? pick_onehot : '0;
      reject       <= do_reject;
      timeout_err  <= do_timeout;
      if (do_grant) begin
        turn   <= pick_idx;
        letter <= pick_letter;
        ptr    <= ptr_next;
      end
      if (do_accept) begin
        guess        <= norm;
        guessed_mask <= guessed_mask | letter_onehot;
        cnt          <= '0;
      end else if (state == ISSUE && !red_busy) begin
        cnt <= cnt + 8'd1;
      end
      if (state == DONE && !word_valid) guessed_mask <= '0;
    end
  end

  assign busy = (state != IDLE) && (state != DONE);

endmodule
